ram_req_ctrl: RTL and testbench

//  - Request/response front end for the 256x16 single-port RAM.
//  - Turns a valid/ready request stream from the core into the RAM's init/rd/wr/mem_addr/mem_dat_in strobes.
//  - Captures the registered RAM read data and returns it on a valid/ready response port.
//  - One transaction in flight; the sole master of the RAM port.

---
 rtl/ram_req_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ram_req_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready request front end for a single-port 256x16 RAM.
// Optional feature: define CLEAR_ON_RESET_EN to fill the RAM with CLEAR_VAL after reset.
module ram_req_ctrl #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
`ifdef CLEAR_ON_RESET_EN
  ,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wr_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              busy_o,
  output logic              init_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_dat_in_o,
  input  logic [DATA_W-1:0] mem_dat_out_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RWAIT = 3'd3,
    ST_RESP  = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

`ifdef CLEAR_ON_RESET_EN
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam state_e      RST_STATE = ST_CLEAR;
  logic [CNT_W-1:0] clr_cnt_q;
`else
  localparam state_e      RST_STATE = ST_IDLE;
`endif

  state_e            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              busy_q;
  logic              init_q;
  logic              rd_q;
  logic              wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_dat_in_q;

  // Transaction sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      busy_q       <= 1'b0;
      init_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_dat_in_q <= '0;
`ifdef CLEAR_ON_RESET_EN
      clr_cnt_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // req_ready_q gates acceptance so the first cycle after reset never accepts
          if (req_valid_i && req_ready_q) begin
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            init_q       <= 1'b1;
            mem_addr_q   <= req_addr_i;
            mem_dat_in_q <= req_wdata_i;
            if (req_wr_i) begin
              wr_q    <= 1'b1;
              state_q <= ST_WRITE;
            end else begin
              rd_q    <= 1'b1;
              state_q <= ST_READ;
            end
          end else begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_WRITE: begin
          init_q      <= 1'b0;
          wr_q        <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        ST_READ: begin
          init_q  <= 1'b0;
          rd_q    <= 1'b0;
          state_q <= ST_RWAIT;
        end
        ST_RWAIT: begin
          rsp_rdata_q <= mem_dat_out_i;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
`ifdef CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          // counter MSB set means every address has been written
          if (clr_cnt_q[ADDR_W]) begin
            init_q      <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end else begin
            init_q       <= 1'b1;
            wr_q         <= 1'b1;
            busy_q       <= 1'b1;
            mem_addr_q   <= clr_cnt_q[ADDR_W-1:0];
            mem_dat_in_q <= CLEAR_VAL;
            clr_cnt_q    <= clr_cnt_q + CNT_W'(1);
          end
        end
`endif
        default: begin
          init_q      <= 1'b0;
          rd_q        <= 1'b0;
          wr_q        <= 1'b0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_rdata_o  = rsp_rdata_q;
  assign busy_o       = busy_q;
  assign init_o       = init_q;
  assign rd_o         = rd_q;
  assign wr_o         = wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_dat_in_o = mem_dat_in_q;

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Self-checking bench for ram_req_ctrl with a behavioural RAM and a shadow memory model.
module tb_ram_req_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] CLR = 16'h5A5A;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              busy, init, rd, wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dat_in, mem_dat_out;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM the controller talks to, and the bench's own view of what it should hold
  logic [DATA_W-1:0] ram     [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  ram_req_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
`ifdef CLEAR_ON_RESET_EN
    ,
    .CLEAR_VAL(CLR)
`endif
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wr_i     (req_wr),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .busy_o       (busy),
    .init_o       (init),
    .rd_o         (rd),
    .wr_o         (wr),
    .mem_addr_o   (mem_addr),
    .mem_dat_in_o (mem_dat_in),
    .mem_dat_out_i(mem_dat_out)
  );

  // Registered single-port RAM: write or read-register on the edge the strobe is sampled
  always @(posedge clk) begin
    if (init && wr) ram[mem_addr] <= mem_dat_in;
    if (init && rd) mem_dat_out <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe sanity on every falling edge
  always @(negedge clk) begin
    check_eq("rd_wr_exclusive", 32'(rd && wr), 32'd0);
    check_eq("strobe_needs_init", 32'((rd || wr) && !init), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!req_ready && n < limit) begin
      tick();
      n++;
    end
    check_eq("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic reset_model();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef CLEAR_ON_RESET_EN
      ref_mem[i] = CLR;
`else
      ref_mem[i] = '0;
`endif
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wait_ready(20);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    tick();
    req_valid = 1'b0;
    check_eq("wr_strobe", 32'(wr), 32'd1);
    check_eq("wr_addr", 32'(mem_addr), 32'(a));
    check_eq("wr_data", 32'(mem_dat_in), 32'(d));
    check_eq("wr_ready_low", 32'(req_ready), 32'd0);
    check_eq("wr_busy", 32'(busy), 32'd1);
    tick();
    check_eq("wr_done", 32'(wr), 32'd0);
    check_eq("wr_ready_back", 32'(req_ready), 32'd1);
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input int stall);
    logic [DATA_W-1:0] exp_d;
    exp_d = ref_mem[a];
    wait_ready(20);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    tick();
    req_valid = 1'b0;
    rsp_ready = 1'($urandom_range(0, 1));
    check_eq("rd_strobe", 32'(rd), 32'd1);
    check_eq("rd_addr", 32'(mem_addr), 32'(a));
    check_eq("rd_no_rsp_c1", 32'(rsp_valid), 32'd0);
    tick();
    check_eq("rd_strobe_drop", 32'(rd), 32'd0);
    check_eq("rd_no_rsp_c2", 32'(rsp_valid), 32'd0);
    tick();
    // third cycle counting the accept cycle as cycle 0
    check_eq("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_d));
    for (int i = 0; i < stall; i++) begin
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_wr = 1'b1;
      req_addr  = 8'($urandom); req_wdata = 16'($urandom);
      tick();
      check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("stall_rdata", 32'(rsp_rdata), 32'(exp_d));
      check_eq("stall_ready_low", 32'(req_ready), 32'd0);
      check_eq("stall_no_wr", 32'(wr), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("hs_rsp_drop", 32'(rsp_valid), 32'd0);
    check_eq("hs_ready_back", 32'(req_ready), 32'd1);
    check_eq("hs_busy_low", 32'(busy), 32'd0);
  endtask

  task automatic post_reset();
`ifdef CLEAR_ON_RESET_EN
    int n = 0;
    int wr_cnt = 0;
    while (!req_ready && n < 400) begin
      tick();
      n++;
      if (wr) wr_cnt++;
    end
    check_eq("clr_ready_low_256", 32'(n >= 256), 32'd1);
    check_eq("clr_wr_count", 32'(wr_cnt), 32'd256);
    check_eq("clr_done_ready", 32'(req_ready), 32'd1);
`else
    tick();
    check_eq("idle_ready", 32'(req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
`endif
    reset_model();
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    reset_model();
    tick();
    tick();
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_strobes", 32'({init, rd, wr}), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
    rst_n = 1'b1;
    post_reset();

`ifdef CLEAR_ON_RESET_EN
    do_read(8'h00, 0);
    do_read(8'hFF, 1);
`endif

    // basic write/read
    do_write(8'h10, 16'h00A5);
    do_read(8'h10, 0);

    // top address must not alias address 0
    do_write(8'hFF, 16'hBEEF);
    do_write(8'h00, 16'h1234);
    do_read(8'hFF, 0);
    do_read(8'h00, 2);

    // held response under backpressure
    do_read(8'h10, 5);

    // back-to-back writes with req_valid held high
    wait_ready(20);
    req_valid = 1'b1; req_wr = 1'b1;
    req_addr = 8'h20; req_wdata = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("b2b_wr_pattern", 32'(wr), 32'((i % 2) == 0));
      if ((i % 2) == 0) begin
        check_eq("b2b_addr", 32'(mem_addr), 32'(8'h20 + 8'(i / 2)));
        ref_mem[req_addr] = req_wdata;
        req_addr  = 8'h20 + 8'(i / 2 + 1);
        req_wdata = 16'($urandom);
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) do_read(8'h20 + 8'(i), 0);

    // randomized traffic against the shadow model
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, 16'($urandom));
      else do_read(a, int'($urandom_range(0, 4)));
    end

    // reset while the read is waiting on RAM data
    wait_ready(20);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_strobes", 32'({init, rd, wr}), 32'd0);
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    check_eq("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
`ifndef CLEAR_ON_RESET_EN
    // RAM survives reset without the clear feature, so keep the model as is
    for (int i = 0; i < DEPTH; i++) ram_keep(i);
`endif
    post_reset_keep();
    check_eq("after_rst_no_rsp", 32'(rsp_valid), 32'd0);
    do_read(8'h10, 0);
    do_read(8'hFF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Without the clear feature the shadow model must not be wiped on reset
  logic [DATA_W-1:0] keep_mem [DEPTH];
  task automatic ram_keep(input int i);
    keep_mem[i] = ref_mem[i];
  endtask

  task automatic post_reset_keep();
    post_reset();
`ifndef CLEAR_ON_RESET_EN
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = keep_mem[i];
`endif
  endtask

endmodule
